// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction/data memory responder:
//   - state_e        : responder FSM encoding (IDLE / BUSY / DONE)
//   - DEPTH_LOG2_DEF : default word-index width (256 x 16-bit words)
//   - LATENCY_DEF    : default request-to-done latency in cycles
//   - CNT_W          : width of the latency down-counter
//   - DATA_W/ADDR_W  : data and byte-address widths
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEPTH_LOG2_DEF = 8;
    localparam int LATENCY_DEF    = 2;
    localparam int CNT_W          = 4;
    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 16;

endpackage

// File: rtl/lat_counter.sv
// -----------------------------------------------------------------------------
// lat_counter
// Loadable down-counter used to time the BUSY phase of imem_resp.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (takes priority over decrement)
//   load_val_i : value to load
//   dec_i      : decrement by one; holds at zero instead of wrapping
//   zero_o     : count is zero
// -----------------------------------------------------------------------------
module lat_counter
    import imem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/imem_resp.sv
// -----------------------------------------------------------------------------
// imem_resp
// Single-outstanding memory responder: accepts one read or write request,
// completes it LATENCY cycles later with a one-cycle done pulse.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (storage is not cleared)
//   req      : request strobe, ignored while stall=1
//   wr       : 1 = write, 0 = read (sampled with req)
//   addr     : byte address; word index = addr[DEPTH_LOG2:1], addr[0]=1 is unaligned
//   data_in  : write data (sampled with req)
//   data_out : last aligned read data, updated on the edge entering DONE
//   stall    : responder busy (state BUSY)
//   done     : completion pulse (state DONE)
//   err      : unaligned access, only together with done
// -----------------------------------------------------------------------------
module imem_resp
    import imem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LATENCY    = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // The counter holds the number of extra BUSY cycles after the first one.
    localparam logic [CNT_W-1:0] LOAD_VAL = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    state_e            state_q, state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_out_q;
    logic              stall_q, done_q, err_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic                  accept;
    logic                  cnt_zero;
    logic                  op_wr;
    logic [ADDR_W-1:0]     op_addr;
    logic [DATA_W-1:0]     op_data;
    logic [DEPTH_LOG2-1:0] op_idx;
    logic                  completing;
    logic                  mem_we;
    logic                  mem_re;
    logic                  unused_addr_hi;

    lat_counter u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept && (LATENCY >= 2)),
        .load_val_i (LOAD_VAL),
        .dec_i      (state_q == ST_BUSY),
        .zero_o     (cnt_zero)
    );

    // NOTE: every signal assigned in this block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = ST_IDLE;
        accept  = 1'b0;
        op_wr   = wr_q;
        op_addr = addr_q;
        op_data = data_q;

        case (state_q)
            ST_BUSY: begin
                state_d = cnt_zero ? ST_DONE : ST_BUSY;
            end
            default: begin
                if (req) begin
                    accept  = 1'b1;
                    state_d = (LATENCY >= 2) ? ST_BUSY : ST_DONE;
                    // With single-cycle latency the access completes on the
                    // accepting edge, so it must use the live request.
                    op_wr   = wr;
                    op_addr = addr;
                    op_data = data_in;
                end
            end
        endcase

        completing = !rst && (state_d == ST_DONE);
        mem_we     = completing && !op_addr[0] && op_wr;
        mem_re     = completing && !op_addr[0] && !op_wr;
    end

    assign op_idx = op_addr[DEPTH_LOG2:1];

    // Address bits above the word index alias onto the same storage.
    assign unused_addr_hi = |(op_addr >> (DEPTH_LOG2 + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            data_out_q <= '0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q   <= wr;
                addr_q <= addr;
                data_q <= data_in;
            end
            if (mem_re) begin
                data_out_q <= mem_q[op_idx];
            end
            stall_q <= (state_d == ST_BUSY);
            done_q  <= (state_d == ST_DONE);
            err_q   <= (state_d == ST_DONE) && op_addr[0];
        end
    end

    // NOTE: the storage array has no reset; clearing it would cost a write
    // port per word and its contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[op_idx] <= op_data;
        end
    end

    assign data_out = data_out_q;
    assign stall    = stall_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_resp.sv
// -----------------------------------------------------------------------------
// tb_imem_resp
// Self-checking bench for imem_resp. The main instance (LATENCY=2) is checked
// against a transaction-level model: an in-flight access completes a fixed
// number of edges after acceptance and updates a plain word array. A second
// instance (LATENCY=1) is checked with directed back-to-back traffic.
// -----------------------------------------------------------------------------
module tb_imem_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [15:0] addr, data_in;
    logic [15:0] data_out;
    logic        stall, done, err;

    logic        req1, wr1;
    logic [15:0] addr1, data_in1;
    logic [15:0] data_out1;
    logic        stall1, done1, err1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] mem_m [256];
    bit          in_flight;
    int          edges_left;
    logic        p_wr;
    logic [15:0] p_addr, p_data;
    logic [15:0] exp_dout;
    logic        exp_done, exp_stall, exp_err;

    always #5 clk = ~clk;

    imem_resp #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .stall(stall), .done(done), .err(err)
    );

    imem_resp #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .wr(wr1), .addr(addr1), .data_in(data_in1),
        .data_out(data_out1), .stall(stall1), .done(done1), .err(err1)
    );

    task automatic model_complete(input logic w, input logic [15:0] a, input logic [15:0] d);
        int idx;
        idx = int'((a >> 1) & 16'h00FF);
        exp_done = 1'b1;
        if (a[0]) exp_err = 1'b1;
        else if (w) mem_m[idx] = d;
        else exp_dout = mem_m[idx];
    endtask

    // Drive one cycle on the main instance, advance the model across the
    // rising edge, and leave time 1 unit after the edge for sampling.
    task automatic cycle(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic rs);
        @(negedge clk);
        req = r; wr = w; addr = a; data_in = d; rst = rs;
        @(posedge clk);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (rs) begin
            in_flight = 1'b0;
            exp_dout  = 16'h0000;
        end else if (in_flight) begin
            edges_left--;
            if (edges_left == 0) begin
                in_flight = 1'b0;
                model_complete(p_wr, p_addr, p_data);
            end
        end else if (r) begin
            if (LAT == 1) begin
                model_complete(w, a, d);
            end else begin
                in_flight  = 1'b1;
                edges_left = LAT - 1;
                p_wr = w; p_addr = a; p_data = d;
            end
        end
        exp_stall = in_flight;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; data_in1 = '0;
        in_flight = 1'b0; exp_dout = '0;
        cycle(1'b1, 1'b1, 16'h0004, 16'hDEAD, 1'b1);
        cycle(1'b1, 1'b1, 16'h0004, 16'hDEAD, 1'b1);
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got=%h exp=0000", data_out); end
        n_checks++; if ({done1, stall1, err1} !== 3'b000) begin n_fail++; $display("FAIL reset_l1_flags got=%b exp=000", {done1, stall1, err1}); end
        n_checks++; if (data_out1 !== 16'h0000) begin n_fail++; $display("FAIL reset_l1_dout got=%h exp=0000", data_out1); end
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if ({done, stall, err} !== 3'b000) begin n_fail++; $display("FAIL idle_flags got=%b exp=000", {done, stall, err}); end
    endtask

    task automatic test_write_read;
        cycle(1'b1, 1'b1, 16'h0004, 16'hBEEF, 1'b0);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wr_stall_c1 got=%b exp=1", stall); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL wr_done_c1 got=%b exp=0", done); end
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if (done !== 1'b1)  begin n_fail++; $display("FAIL wr_done_c2 got=%b exp=1", done); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wr_stall_c2 got=%b exp=0", stall); end
        n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL wr_err got=%b exp=0", err); end
        n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL wr_dout got=%h exp=0000", data_out); end
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL wr_done_pulse got=%b exp=0", done); end

        cycle(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rd_done got=%b exp=1", done); end
        n_checks++; if (data_out !== 16'hBEEF) begin n_fail++; $display("FAIL rd_dout got=%h exp=beef", data_out); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            n_checks++; if (data_out !== 16'hBEEF) begin n_fail++; $display("FAIL rd_hold%0d got=%h exp=beef", i, data_out); end
        end
    endtask

    task automatic test_unaligned_alias;
        cycle(1'b1, 1'b0, 16'h0205, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if ({done, err} !== 2'b11) begin n_fail++; $display("FAIL unal_done_err got=%b exp=11", {done, err}); end
        n_checks++; if (data_out !== 16'hBEEF) begin n_fail++; $display("FAIL unal_dout got=%h exp=beef", data_out); end
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL unal_after got=%b exp=00", {done, err}); end
        cycle(1'b1, 1'b0, 16'h0204, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL alias_done_err got=%b exp=10", {done, err}); end
        n_checks++; if (data_out !== 16'hBEEF) begin n_fail++; $display("FAIL alias_dout got=%h exp=beef", data_out); end
    endtask

    task automatic test_back_to_back;
        cycle(1'b1, 1'b1, 16'h0002, 16'h5A5A, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        // req held high: even slots address 0x0000, odd (stalled) slots 0x0002
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, (i % 2 == 0) ? 16'h0000 : 16'h0002, 16'h1000 + 16'(i), 1'b0);
            n_checks++;
            if ({done, stall} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL b2b_slot%0d got done,stall=%b exp=%b", i, {done, stall},
                                   (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        cycle(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if (data_out !== 16'h5A5A) begin n_fail++; $display("FAIL b2b_ignored got=%h exp=5a5a", data_out); end
        cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if (data_out !== 16'h1006) begin n_fail++; $display("FAIL b2b_last got=%h exp=1006", data_out); end
    endtask

    task automatic test_reset_abort;
        cycle(1'b1, 1'b1, 16'h0010, 16'h1111, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        cycle(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL abort_stall got=%b exp=1", stall); end
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        n_checks++; if ({done, stall} !== 2'b00) begin n_fail++; $display("FAIL abort_rst got=%b exp=00", {done, stall}); end
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_nodone got=%b exp=0", done); end
        cycle(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        n_checks++; if (data_out !== 16'h1111) begin n_fail++; $display("FAIL abort_mem got=%h exp=1111", data_out); end
    endtask

    task automatic test_random;
        logic        r, w, rs;
        logic [15:0] a, d;
        // Preload the word indices the random traffic uses
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 16'(i * 2), 16'($urandom), 1'b0);
            cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        end
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 99) < 70);
            w  = $urandom_range(0, 1) == 1;
            rs = ($urandom_range(0, 99) < 3);
            a  = {7'($urandom), 4'b0000, 4'($urandom), 1'($urandom_range(0, 99) < 20)};
            d  = 16'($urandom);
            cycle(r, w, a, d, rs);
            n_checks++; if (done !== exp_done)   begin n_fail++; $display("FAIL rnd%0d_done got=%b exp=%b", n, done, exp_done); end
            n_checks++; if (stall !== exp_stall) begin n_fail++; $display("FAIL rnd%0d_stall got=%b exp=%b", n, stall, exp_stall); end
            n_checks++; if (err !== exp_err)     begin n_fail++; $display("FAIL rnd%0d_err got=%b exp=%b", n, err, exp_err); end
            n_checks++; if (data_out !== exp_dout) begin n_fail++; $display("FAIL rnd%0d_dout got=%h exp=%h", n, data_out, exp_dout); end
        end
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_latency1;
        logic [15:0] v;
        for (int i = 0; i < 6; i++) begin
            v = 16'hC000 + 16'(i * 17);
            @(negedge clk);
            req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0100 + 16'(i * 2); data_in1 = v;
            @(posedge clk); #1;
            n_checks++; if ({done1, stall1, err1} !== 3'b100) begin n_fail++; $display("FAIL l1_wr%0d got=%b exp=100", i, {done1, stall1, err1}); end
            @(negedge clk);
            wr1 = 1'b0; data_in1 = 16'h0000;
            @(posedge clk); #1;
            n_checks++; if ({done1, stall1} !== 2'b10) begin n_fail++; $display("FAIL l1_rd%0d got=%b exp=10", i, {done1, stall1}); end
            n_checks++; if (data_out1 !== v) begin n_fail++; $display("FAIL l1_dout%0d got=%h exp=%h", i, data_out1, v); end
        end
        @(negedge clk);
        addr1 = 16'h0101;
        @(posedge clk); #1;
        n_checks++; if ({done1, err1} !== 2'b11) begin n_fail++; $display("FAIL l1_unal got=%b exp=11", {done1, err1}); end
        n_checks++; if (data_out1 !== 16'hC055) begin n_fail++; $display("FAIL l1_unal_dout got=%h exp=c055", data_out1); end
        @(negedge clk);
        req1 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({done1, stall1, err1} !== 3'b000) begin n_fail++; $display("FAIL l1_idle got=%b exp=000", {done1, stall1, err1}); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_unaligned_alias();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_latency1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, word-index width (256 x 16-bit words).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to done; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req  input  1  request strobe from fetch/requester; sampled only when not stalled.
REQ-006 wr  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  16  byte address; word index = addr[DEPTH_LOG2:1].
REQ-008 data_in  input  16  write data; sampled with req.
REQ-009 data_out  output  16  read data; valid when done=1 and err=0 for a read.
REQ-010 stall  output  1  responder busy; new req ignored while 1.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  unaligned-access flag; asserted only with done.

Function
REQ-013 States: IDLE, BUSY, DONE; state, counter, captured request and data_out are registered.
REQ-014 Accept: in IDLE or DONE with req=1, capture wr/addr/data_in at the edge; next state BUSY with counter=LATENCY-2 if LATENCY>=2, else DONE.
REQ-015 In IDLE or DONE with req=0: next state IDLE.
REQ-016 BUSY: counter decrements each cycle; when counter=0, next state DONE.
REQ-017 Request accepted at edge k SHALL produce done=1 during exactly cycle k+LATENCY.
REQ-018 stall = 1 iff state=BUSY; done = 1 iff state=DONE.
REQ-019 req asserted while BUSY is ignored; there is no queue.
REQ-020 In DONE a new req is accepted (back-to-back); sustained throughput is one access per LATENCY cycles.
REQ-021 Read (captured addr[0]=0): data_out loads storage[index] on the edge entering DONE; held until the next completed aligned read.
REQ-022 Write (captured addr[0]=0): storage[index] <= captured data_in on the edge entering DONE; data_out unchanged.
REQ-023 Unaligned (captured addr[0]=1): no storage access; data_out unchanged; err=1 during the DONE cycle only.
REQ-024 addr bits above DEPTH_LOG2 are ignored (wrap-around aliasing); no error.
REQ-025 Read of a location written by the immediately preceding completed request returns the new data.
REQ-026 The requester holds no obligation to keep req/addr stable after acceptance.

Reset
REQ-027 rst=1 at an edge: state=IDLE, counter=0, data_out=0, captured registers=0; stall=0, done=0, err=0 in the following cycle.
REQ-028 Reset mid-BUSY aborts the access; a pending write SHALL NOT modify storage.
REQ-029 Storage contents are not cleared by reset.
REQ-030 rst has priority over req in the same cycle.

Structure
REQ-031 Shared package imem_pkg: state encoding (IDLE/BUSY/DONE), DEPTH_LOG2 and LATENCY defaults.
REQ-032 One sub-module lat_counter: 4-bit loadable down-counter with zero flag; storage array and FSM stay in imem_resp.

Verification
REQ-033 Reset, then write addr=0x0004 data=0xBEEF -> done at cycle 2 after accept, stall=1 in cycle 1, err=0, data_out=0x0000.
REQ-034 Read addr=0x0004 -> done at accept+2, data_out=0xBEEF held until the next aligned read.
REQ-035 Read addr=0x0205 -> done=1, err=1, data_out unchanged; then read 0x0204 -> 0xBEEF (wrap alias of 0x0004).
REQ-036 req=1 held continuously with addresses 0x0000,0x0002 -> done every 2 cycles; req during stall ignored (addresses issued while stalled never complete).
REQ-037 Write 0x0010=0x1234 with rst=1 during BUSY -> no done; later read 0x0010 returns the prior value, not 0x1234.
REQ-038 LATENCY=1 build: req every cycle -> done every cycle, stall never asserted.
